// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared constants, state encoding and frame check for cmd_master
//
// Purpose: framing bytes, opcodes, response status codes, FSM state enum
//          and the command-body status check used by cmd_master.
// Ports:   none (package).

package cmd_pkg;

   localparam logic [7:0] SOF      = 8'hA5;
   localparam logic [7:0] RSP      = 8'h5A;
   localparam logic [7:0] OP_WR    = 8'h01;
   localparam logic [7:0] OP_RD    = 8'h02;

   localparam logic [7:0] ST_OK    = 8'h00;
   localparam logic [7:0] ST_CHK   = 8'h01;
   localparam logic [7:0] ST_OP    = 8'h02;
   localparam logic [7:0] ST_RD_TO = 8'h03;

   typedef enum logic [2:0] {
      S_HUNT,
      S_COLLECT,
      S_CHECK,
      S_WRITE,
      S_READ_REQ,
      S_READ_WAIT,
      S_RESP
   } state_t;

   // body = {OP, AH, AL, DH, DL, CHK}; checksum is judged before the opcode
   function automatic logic [7:0] frame_status(input logic [47:0] body);
      logic [7:0] sum;
      sum = body[47:40] ^ body[39:32] ^ body[31:24] ^ body[23:16] ^ body[15:8];
      if (sum != body[7:0]) begin
         return ST_CHK;
      end else if (body[47:40] != OP_WR && body[47:40] != OP_RD) begin
         return ST_OP;
      end else begin
         return ST_OK;
      end
   endfunction

endpackage

// File: rtl/cmd_tx_ser.sv
// rtl/cmd_tx_ser.sv - 5-byte response serialiser with valid/ready handshake
//
// Purpose: latches a 5-byte response on load and presents it byte by byte,
//          holding each byte until the sink accepts it.
// Ports:   clk, reset (sync, active high)
//          load, load_data[39:0]  response, first byte in [39:32]
//          tdata[7:0], tvalid     registered byte stream out
//          tready                 sink accepts when tvalid && tready
//          tlast                  current byte is the final one

module cmd_tx_ser (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [39:0] load_data,
   output logic [7:0]  tdata,
   output logic        tvalid,
   input  logic        tready,
   output logic        tlast
);

   logic [31:0] rest_q;
   logic [2:0]  idx_q;

   assign tlast = (idx_q == 3'd4);

   always_ff @(posedge clk) begin
      if (reset) begin
         tdata  <= 8'h00;
         tvalid <= 1'b0;
         rest_q <= 32'h0;
         idx_q  <= 3'd0;
      end else if (load) begin
         tdata  <= load_data[39:32];
         rest_q <= load_data[31:0];
         tvalid <= 1'b1;
         idx_q  <= 3'd0;
      end else if (tvalid && tready) begin
         if (tlast) begin
            tvalid <= 1'b0;
            tdata  <= 8'h00;
            idx_q  <= 3'd0;
         end else begin
            tdata  <= rest_q[31:24];
            rest_q <= {rest_q[23:0], 8'h00};
            idx_q  <= idx_q + 3'd1;
         end
      end
   end

endmodule

// File: rtl/cmd_master.sv
// rtl/cmd_master.sv - byte-stream command frame parser driving the set_* register bus
//
// Purpose: parses A5-framed 7-byte commands, issues one register write or read,
//          returns a 5-byte 5A-framed response.
// Ports:   clk_i, reset_i (sync, active high)
//          rx_data/rx_valid/rx_ready        command byte stream in
//          tx_data/tx_valid/tx_ready        response byte stream out
//          set_wr_en/set_wr_addr/set_wr_data register write strobe
//          set_rd_en/set_rd_addr            register read strobe
//          set_rd_data/set_rd_data_en       read return
//          frame_err                        one-cycle error pulse

module cmd_master
   import cmd_pkg::*;
#(
   parameter int RD_TIMEOUT    = 8,
   parameter int FRAME_TIMEOUT = 1000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        set_wr_en,
   output logic [15:0] set_wr_addr,
   output logic [15:0] set_wr_data,
   output logic        set_rd_en,
   output logic [15:0] set_rd_addr,
   input  logic [15:0] set_rd_data,
   input  logic        set_rd_data_en,
   output logic        frame_err
);

   state_t      state, state_nxt;
   logic [2:0]  byte_cnt, byte_cnt_nxt;
   logic [15:0] idle_cnt, idle_cnt_nxt;
   logic [7:0]  wait_cnt, wait_cnt_nxt;
   logic [47:0] frame_q, frame_nxt;

   logic        rx_ready_nxt;
   logic        wr_en_nxt, rd_en_nxt, frame_err_nxt;
   logic [15:0] wr_addr_nxt, wr_data_nxt, rd_addr_nxt;

   logic        accept;
   logic        tx_last;
   logic        load;
   logic [7:0]  load_st;
   logic [15:0] load_rd;
   logic [39:0] load_data;

   // rx_ready is registered and tracks the state, so a handshake always
   // lands in HUNT or COLLECT
   assign accept    = rx_valid && rx_ready;
   assign load_data = {RSP, load_st, load_rd, load_st ^ load_rd[15:8] ^ load_rd[7:0]};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= S_HUNT;
         byte_cnt    <= 3'd0;
         idle_cnt    <= 16'd0;
         wait_cnt    <= 8'd0;
         frame_q     <= 48'h0;
         rx_ready    <= 1'b0;
         set_wr_en   <= 1'b0;
         set_wr_addr <= 16'h0;
         set_wr_data <= 16'h0;
         set_rd_en   <= 1'b0;
         set_rd_addr <= 16'h0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         byte_cnt    <= byte_cnt_nxt;
         idle_cnt    <= idle_cnt_nxt;
         wait_cnt    <= wait_cnt_nxt;
         frame_q     <= frame_nxt;
         rx_ready    <= rx_ready_nxt;
         set_wr_en   <= wr_en_nxt;
         set_wr_addr <= wr_addr_nxt;
         set_wr_data <= wr_data_nxt;
         set_rd_en   <= rd_en_nxt;
         set_rd_addr <= rd_addr_nxt;
         frame_err   <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      byte_cnt_nxt  = byte_cnt;
      idle_cnt_nxt  = idle_cnt;
      wait_cnt_nxt  = wait_cnt;
      frame_nxt     = frame_q;
      wr_en_nxt     = 1'b0;
      wr_addr_nxt   = set_wr_addr;
      wr_data_nxt   = set_wr_data;
      rd_en_nxt     = 1'b0;
      rd_addr_nxt   = set_rd_addr;
      frame_err_nxt = 1'b0;
      load          = 1'b0;
      load_st       = ST_OK;
      load_rd       = 16'h0;

      case (state)
         S_HUNT: begin
            if (accept && rx_data == SOF) begin
               state_nxt    = S_COLLECT;
               byte_cnt_nxt = 3'd0;
               idle_cnt_nxt = 16'd0;
            end
         end
         S_COLLECT: begin
            if (accept) begin
               frame_nxt    = {frame_q[39:0], rx_data};
               idle_cnt_nxt = 16'd0;
               byte_cnt_nxt = byte_cnt + 3'd1;
               if (byte_cnt == 3'd5) begin
                  state_nxt     = S_CHECK;
                  // judged on entry so the pulse lines up with the CHECK cycle
                  frame_err_nxt = (frame_status(frame_nxt) != ST_OK);
               end
            end else if (idle_cnt == 16'(FRAME_TIMEOUT - 1)) begin
               frame_err_nxt = 1'b1;
               state_nxt     = S_HUNT;
            end else begin
               idle_cnt_nxt = idle_cnt + 16'd1;
            end
         end
         S_CHECK: begin
            if (frame_status(frame_q) != ST_OK) begin
               load      = 1'b1;
               load_st   = frame_status(frame_q);
               state_nxt = S_RESP;
            end else if (frame_q[47:40] == OP_WR) begin
               state_nxt   = S_WRITE;
               wr_en_nxt   = 1'b1;
               wr_addr_nxt = frame_q[39:24];
               wr_data_nxt = frame_q[23:8];
            end else begin
               state_nxt   = S_READ_REQ;
               rd_en_nxt   = 1'b1;
               rd_addr_nxt = frame_q[39:24];
            end
         end
         S_WRITE: begin
            load      = 1'b1;
            state_nxt = S_RESP;
         end
         S_READ_REQ: begin
            // wait_cnt holds k, the number of cycles since set_rd_en
            wait_cnt_nxt = 8'd1;
            state_nxt    = S_READ_WAIT;
         end
         S_READ_WAIT: begin
            if (set_rd_data_en) begin
               load      = 1'b1;
               load_rd   = set_rd_data;
               state_nxt = S_RESP;
            end else if (wait_cnt == 8'(RD_TIMEOUT)) begin
               load          = 1'b1;
               load_st       = ST_RD_TO;
               frame_err_nxt = 1'b1;
               state_nxt     = S_RESP;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_RESP: begin
            if (tx_valid && tx_ready && tx_last) begin
               state_nxt = S_HUNT;
            end
         end
         default: begin
            state_nxt = S_HUNT;
         end
      endcase

      rx_ready_nxt = (state_nxt == S_HUNT) || (state_nxt == S_COLLECT);
   end

   cmd_tx_ser u_tx_ser (
      .clk       (clk_i),
      .reset     (reset_i),
      .load      (load),
      .load_data (load_data),
      .tdata     (tx_data),
      .tvalid    (tx_valid),
      .tready    (tx_ready),
      .tlast     (tx_last)
   );

endmodule

// File: tb/tb_cmd_master.sv
// tb/tb_cmd_master.sv - directed self-checking bench for cmd_master

module tb_cmd_master;

   localparam int RD_TO = 8;
   localparam int FR_TO = 24;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        set_wr_en;
   logic [15:0] set_wr_addr;
   logic [15:0] set_wr_data;
   logic        set_rd_en;
   logic [15:0] set_rd_addr;
   logic [15:0] set_rd_data;
   logic        set_rd_data_en;
   logic        frame_err;

   always #5 clk = ~clk;

   cmd_master #(.RD_TIMEOUT(RD_TO), .FRAME_TIMEOUT(FR_TO)) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .set_wr_en      (set_wr_en),
      .set_wr_addr    (set_wr_addr),
      .set_wr_data    (set_wr_data),
      .set_rd_en      (set_rd_en),
      .set_rd_addr    (set_rd_addr),
      .set_rd_data    (set_rd_data),
      .set_rd_data_en (set_rd_data_en),
      .frame_err      (frame_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0, overlap = 0;
   int wr_cyc = 0, rd_cyc = 0, ferr_cyc = 0;
   logic [15:0] wr_addr_seen = 16'h0, wr_data_seen = 16'h0;
   logic [7:0] rsp_q[$];
   int         rsp_cyc_q[$];

   int          tx_mode = 1;    // 0 stalled, 1 always ready, 2 toggling
   logic        resp_on = 1'b1;
   int          resp_dly = 1;
   logic [15:0] resp_val = 16'hBEEF;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (set_wr_en) begin
         wr_cnt       <= wr_cnt + 1;
         wr_cyc       <= cyc;
         wr_addr_seen <= set_wr_addr;
         wr_data_seen <= set_wr_data;
      end
      if (set_rd_en) begin
         rd_cnt <= rd_cnt + 1;
         rd_cyc <= cyc;
      end
      if (frame_err) begin
         ferr_cnt <= ferr_cnt + 1;
         ferr_cyc <= cyc;
      end
      if (set_wr_en && set_rd_en) overlap <= overlap + 1;
      if (tx_valid && tx_ready) begin
         rsp_q.push_back(tx_data);
         rsp_cyc_q.push_back(cyc);
      end
   end

   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (tx_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ~tx_ready;
         endcase
      end
   end

   initial begin
      set_rd_data_en = 1'b0;
      set_rd_data    = 16'h0;
      forever begin
         @(posedge clk); #1;
         if (set_rd_en && resp_on && !reset_i) begin
            repeat (resp_dly) @(posedge clk);
            #1;
            set_rd_data_en = 1'b1;
            set_rd_data    = resp_val;
            @(posedge clk); #1;
            set_rd_data_en = 1'b0;
            set_rd_data    = 16'h0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 100) begin
         step(1);
         n++;
      end
      if (!rx_ready) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
      step(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [55:0] f);
      for (int i = 0; i < 7; i++) send_byte(f[55-8*i -: 8]);
   endtask

   task automatic rsp_clear();
      rsp_q.delete();
      rsp_cyc_q.delete();
   endtask

   task automatic expect_rsp(input string tag, input logic [39:0] exp);
      int n;
      n = 0;
      while (rsp_q.size() < 5 && n < 300) begin
         step(1);
         n++;
      end
      step(4);
      chk({tag, "_len"}, 32'(rsp_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < rsp_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(rsp_q[i]), 32'(exp[39-8*i -: 8]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_wr_en"}, 32'(set_wr_en), 32'd0);
      chk({tag, "_rd_en"}, 32'(set_rd_en), 32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_wr_addr"}, 32'(set_wr_addr), 32'd0);
      chk({tag, "_wr_data"}, 32'(set_wr_data), 32'd0);
      chk({tag, "_rd_addr"}, 32'(set_rd_addr), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, w0, r0, f0, n;
      reset_i  = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      step(3);
      check_reset_outputs("rst");
      reset_i = 1'b0;
      step(1);
      chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

      // write with ideal source and sink: 7 + CHECK + WRITE + 5 cycles
      rsp_clear();
      t0 = cyc;
      send_frame(56'hA5_01_00_11_12_34_36);
      expect_rsp("wr", 40'h5A_00_00_00_00);
      chk("wr_cnt", 32'(wr_cnt), 32'd1);
      chk("wr_addr", 32'(wr_addr_seen), 32'h0011);
      chk("wr_data", 32'(wr_data_seen), 32'h1234);
      chk("wr_strobe_cyc", 32'(wr_cyc), 32'(t0 + 8));
      chk("wr_first_tx_cyc", 32'(rsp_cyc_q[0]), 32'(t0 + 9));
      chk("wr_last_tx_cyc", 32'(rsp_cyc_q[4]), 32'(t0 + 13));
      chk("wr_no_rd", 32'(rd_cnt), 32'd0);

      // read answered one cycle after the strobe
      rsp_clear();
      resp_on = 1'b1; resp_dly = 1; resp_val = 16'hBEEF;
      send_frame(56'hA5_02_00_12_00_00_10);
      expect_rsp("rd", 40'h5A_00_BE_EF_51);
      chk("rd_cnt", 32'(rd_cnt), 32'd1);
      chk("rd_addr", 32'(set_rd_addr), 32'h0012);
      chk("rd_no_ferr", 32'(ferr_cnt), 32'd0);

      // read answered on the last allowed cycle k = RD_TIMEOUT
      rsp_clear();
      resp_dly = RD_TO; resp_val = 16'h1357;
      send_frame(56'hA5_02_00_12_00_00_10);
      expect_rsp("rd_late", 40'h5A_00_13_57_44);
      chk("rd_late_no_ferr", 32'(ferr_cnt), 32'd0);

      // read with no answer
      rsp_clear();
      resp_on = 1'b0;
      w0 = wr_cnt;
      send_frame(56'hA5_02_00_34_00_00_36);
      expect_rsp("rd_to", 40'h5A_03_00_00_03);
      chk("rd_to_ferr", 32'(ferr_cnt), 32'd1);
      chk("rd_to_ferr_cyc", 32'(ferr_cyc), 32'(rd_cyc + RD_TO + 1));
      chk("rd_to_addr", 32'(set_rd_addr), 32'h0034);
      chk("rd_to_no_wr", 32'(wr_cnt), 32'(w0));
      resp_on = 1'b1; resp_dly = 1; resp_val = 16'hBEEF;

      // checksum error
      rsp_clear();
      w0 = wr_cnt; r0 = rd_cnt; f0 = ferr_cnt;
      t0 = cyc;
      send_frame(56'hA5_01_00_11_12_34_00);
      expect_rsp("bad_chk", 40'h5A_01_00_00_01);
      chk("bad_chk_ferr", 32'(ferr_cnt), 32'(f0 + 1));
      chk("bad_chk_ferr_cyc", 32'(ferr_cyc), 32'(t0 + 7));
      chk("bad_chk_no_wr", 32'(wr_cnt), 32'(w0));
      chk("bad_chk_no_rd", 32'(rd_cnt), 32'(r0));

      // bad opcode with good checksum
      rsp_clear();
      f0 = ferr_cnt;
      send_frame(56'hA5_07_00_00_00_00_07);
      expect_rsp("bad_op", 40'h5A_02_00_00_02);
      chk("bad_op_ferr", 32'(ferr_cnt), 32'(f0 + 1));
      chk("bad_op_no_wr", 32'(wr_cnt), 32'(w0));

      // garbage before SOF
      rsp_clear();
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      send_frame(56'hA5_01_00_22_AB_CD_45);
      expect_rsp("resync", 40'h5A_00_00_00_00);
      chk("resync_wr_cnt", 32'(wr_cnt), 32'(w0 + 1));
      chk("resync_wr_addr", 32'(wr_addr_seen), 32'h0022);
      chk("resync_wr_data", 32'(wr_data_seen), 32'hABCD);

      // frame abandoned after 3 bytes
      rsp_clear();
      w0 = wr_cnt; f0 = ferr_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      t0 = cyc;
      step(FR_TO + 5);
      chk("fto_ferr", 32'(ferr_cnt), 32'(f0 + 1));
      chk("fto_ferr_cyc", 32'(ferr_cyc), 32'(t0 + FR_TO));
      chk("fto_no_rsp", 32'(rsp_q.size()), 32'd0);
      chk("fto_no_wr", 32'(wr_cnt), 32'(w0));
      send_frame(56'hA5_01_00_11_12_34_36);
      expect_rsp("fto_next", 40'h5A_00_00_00_00);
      chk("fto_next_wr", 32'(wr_cnt), 32'(w0 + 1));

      // toggling sink
      rsp_clear();
      tx_mode = 2;
      send_frame(56'hA5_02_00_12_00_00_10);
      expect_rsp("toggle", 40'h5A_00_BE_EF_51);
      tx_mode = 1;

      // reset while waiting for read data
      rsp_clear();
      resp_on = 1'b0;
      r0 = rd_cnt;
      send_frame(56'hA5_02_00_12_00_00_10);
      n = 0;
      while (rd_cnt == r0 && n < 50) begin step(1); n++; end
      chk("rw_saw_rd_en", 32'(rd_cnt), 32'(r0 + 1));
      step(2);
      reset_i = 1'b1;
      step(1);
      check_reset_outputs("rst_rw");
      reset_i = 1'b0;
      w0 = wr_cnt; r0 = rd_cnt; f0 = ferr_cnt;
      step(20);
      chk("rst_rw_no_rsp", 32'(rsp_q.size()), 32'd0);
      chk("rst_rw_no_ferr", 32'(ferr_cnt), 32'(f0));
      chk("rst_rw_no_strobe", 32'(wr_cnt + rd_cnt), 32'(w0 + r0));
      resp_on = 1'b1;

      // reset while a response is stalled
      rsp_clear();
      tx_mode = 0;
      send_frame(56'hA5_01_00_11_12_34_36);
      n = 0;
      while (!tx_valid && n < 50) begin step(1); n++; end
      chk("rr_saw_tx_valid", 32'(tx_valid), 32'd1);
      reset_i = 1'b1;
      step(1);
      check_reset_outputs("rst_rr");
      reset_i = 1'b0;
      tx_mode = 1;
      w0 = wr_cnt; r0 = rd_cnt;
      step(20);
      chk("rst_rr_no_rsp", 32'(rsp_q.size()), 32'd0);
      chk("rst_rr_no_strobe", 32'(wr_cnt + rd_cnt), 32'(w0 + r0));
      send_frame(56'hA5_01_00_22_AB_CD_45);
      expect_rsp("after_rst", 40'h5A_00_00_00_00);
      chk("after_rst_wr_cnt", 32'(wr_cnt), 32'(w0 + 1));
      chk("after_rst_wr_addr", 32'(wr_addr_seen), 32'h0022);
      chk("after_rst_wr_data", 32'(wr_data_seen), 32'hABCD);

      chk("wr_rd_overlap", 32'(overlap), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
